nco_phase_gen: RTL and testbench



---
 rtl/nco_pkg.sv | 22 ++
 rtl/nco_lfsr.sv | 28 ++
 rtl/nco_phase_gen.sv | 116 +++++++++++
 tb/tb_nco_phase_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants for the NCO phase generator: default sizes, FSM encodings and LFSR constants.
// The dither LFSR constants are only consumed when NCO_DITHER_EN is defined.
package nco_pkg;

    localparam int ACC_W_DEF      = 16;
    localparam int PHASE_W_DEF    = 10;
    localparam int SINCOS_LAT_DEF = 4;
    localparam int DITHER_W_DEF   = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/nco_lfsr.sv
// 16-bit Fibonacci LFSR that supplies phase dither to nco_phase_gen.
// Defined only when NCO_DITHER_EN is set, since nothing else uses it.
`ifdef NCO_DITHER_EN
module nco_lfsr
    import nco_pkg::*;
#(
    parameter int OUT_W = DITHER_W_DEF
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             adv,
    output logic [OUT_W-1:0] dither
);

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= LFSR_SEED;
        end else if (adv) begin
            state <= {state[14:0], lfsr_feedback(state)};
        end
    end

    assign dither = state[OUT_W-1:0];

endmodule
`endif

// File: rtl/nco_phase_gen.sv
// Phase accumulator feeding sincos, with phase-continuous FTW retune at the accumulator wrap.
// Optional phase dither is enabled by defining NCO_DITHER_EN.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int SINCOS_LAT = SINCOS_LAT_DEF,
    parameter int DITHER_W   = DITHER_W_DEF
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               en,
    input  logic [ACC_W-1:0]   ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    input  logic [PHASE_W-1:0] poff,
    output logic [PHASE_W-1:0] a,
    output logic               a_valid,
    output logic               sc_valid,
    output logic               wrap
);

    if (DITHER_W > ACC_W - PHASE_W) begin : g_bad_dither
        $error("DITHER_W must not exceed ACC_W-PHASE_W");
    end

    logic [1:0]            state;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      ftw_reg;
    logic [ACC_W-1:0]      ftw_pend;
    logic [ACC_W:0]        sum;
    logic                  carry_q;
    logic [SINCOS_LAT-1:0] sc_pipe;
    logic                  running;
    logic                  accept;
    logic [PHASE_W-1:0]    phase_src;

    assign sum       = {1'b0, acc} + {1'b0, ftw_reg};
    assign running   = (state != IDLE);
    assign ftw_ready = (state != PENDING);
    assign accept    = ftw_valid && ftw_ready;
    assign sc_valid  = sc_pipe[SINCOS_LAT-1];

`ifdef NCO_DITHER_EN
    logic [DITHER_W-1:0] dither;
    logic [ACC_W-1:0]    acc_dith;

    nco_lfsr #(.OUT_W(DITHER_W)) u_lfsr (
        .clk    (clk),
        .areset (areset),
        .adv    (a_valid),
        .dither (dither)
    );

    assign acc_dith  = acc + ACC_W'(dither);
    assign phase_src = acc_dith[ACC_W-1 -: PHASE_W];
`else
    assign phase_src = acc[ACC_W-1 -: PHASE_W];
`endif

    // The carry is held one extra cycle so wrap lines up with the first angle of the new period.
    always_ff @(posedge clk) begin
        if (areset) begin
            state    <= IDLE;
            acc      <= '0;
            ftw_reg  <= '0;
            ftw_pend <= '0;
            carry_q  <= 1'b0;
            wrap     <= 1'b0;
            a        <= '0;
            a_valid  <= 1'b0;
            sc_pipe  <= '0;
        end else begin
            a       <= phase_src + poff;
            a_valid <= running;
            sc_pipe <= (sc_pipe << 1) | SINCOS_LAT'(a_valid);
            carry_q <= running && sum[ACC_W];
            wrap    <= carry_q;
            if (running) begin
                acc <= sum[ACC_W-1:0];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        ftw_reg <= ftw_in;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if (accept) begin
                            ftw_reg <= ftw_in;
                        end
                        state <= IDLE;
                    end else if (accept) begin
                        ftw_pend <= ftw_in;
                        state    <= PENDING;
                    end
                end
                PENDING: begin
                    // A zero FTW never carries, so apply the pending word immediately.
                    if (sum[ACC_W] || (ftw_reg == '0) || !en) begin
                        ftw_reg <= ftw_pend;
                        state   <= en ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen (default parameters, NCO_DITHER_EN undefined).
// Expected outputs are queued as each stimulus is driven and compared after the clock edge.
module tb_nco_phase_gen;

    logic        clk = 1'b0;
    logic        areset;
    logic        en;
    logic [15:0] ftw_in;
    logic        ftw_valid;
    logic        ftw_ready;
    logic [9:0]  poff;
    logic [9:0]  a;
    logic        a_valid;
    logic        sc_valid;
    logic        wrap;

    always #5 clk = ~clk;

    nco_phase_gen dut (
        .clk       (clk),
        .areset    (areset),
        .en        (en),
        .ftw_in    (ftw_in),
        .ftw_valid (ftw_valid),
        .ftw_ready (ftw_ready),
        .poff      (poff),
        .a         (a),
        .a_valid   (a_valid),
        .sc_valid  (sc_valid),
        .wrap      (wrap)
    );

    typedef struct {
        string      name;
        logic [9:0] a;
        logic       av;
        logic       sc;
        logic       w;
        logic       rdy;
        logic       ca;
    } exp_t;

    typedef struct {
        logic        r;
        logic        e;
        logic        fv;
        logic [15:0] f;
        logic [9:0]  p;
        logic [9:0]  ea;
        logic        eav;
        logic        esc;
        logic        ew;
        logic        erdy;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(string n, int ea, logic av, logic sc, logic w, logic rdy, logic ca);
        exp_t x;
        x.name = n;
        x.a    = 10'(ea & 'h3FF);
        x.av   = av;
        x.sc   = sc;
        x.w    = w;
        x.rdy  = rdy;
        x.ca   = ca;
        return x;
    endfunction

    task automatic checkOutput();
        exp_t x;
        if (sb.size() == 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        x = sb.pop_front();
        if (x.ca && (a !== x.a)) begin
            n_err++;
            $display("[TB] FAIL %s a: got %h want %h (vector %0d)", x.name, a, x.a, n_vec);
        end
        if (a_valid !== x.av) begin
            n_err++;
            $display("[TB] FAIL %s a_valid: got %b want %b (vector %0d)", x.name, a_valid, x.av, n_vec);
        end
        if (sc_valid !== x.sc) begin
            n_err++;
            $display("[TB] FAIL %s sc_valid: got %b want %b (vector %0d)", x.name, sc_valid, x.sc, n_vec);
        end
        if (wrap !== x.w) begin
            n_err++;
            $display("[TB] FAIL %s wrap: got %b want %b (vector %0d)", x.name, wrap, x.w, n_vec);
        end
        if (ftw_ready !== x.rdy) begin
            n_err++;
            $display("[TB] FAIL %s ftw_ready: got %b want %b (vector %0d)", x.name, ftw_ready, x.rdy, n_vec);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic fv,
                                 input logic [15:0] f, input logic [9:0] p, input exp_t x);
        areset    = r;
        en        = e;
        ftw_valid = fv;
        ftw_in    = f;
        poff      = p;
        sb.push_back(x);
        n_vec++;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset(input string n);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 10'h0, mk(n, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ea;

        // Reset, FTW 0x0040 load in IDLE, then run: first valid angle is the held acc.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0040, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h001, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h002, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h003, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h004, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 10'h005, 1'b1, 1'b1, 1'b0, 1'b1};

        $display("[TB] reset and unit step");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].r, tbl[i].e, tbl[i].fv, tbl[i].f, tbl[i].p,
                          mk($sformatf("tbl%0d", i), int'(tbl[i].ea), tbl[i].eav,
                             tbl[i].esc, tbl[i].ew, tbl[i].erdy, 1'b1));
        end
        ea = 6;
        for (int n = 0; n < 1030; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h0,
                          mk("unit_step", ea, 1'b1, 1'b1, (ea == 0), 1'b1, 1'b1));
            ea = (ea + 1) % 1024;
        end

        $display("[TB] offset");
        doReset("off_reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000, 10'h180, mk("off_load", 'h180, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h180, mk("off_start", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h180,
                          mk("offset", 'h180 + k * 'h40, 1'b1, (k >= 4), (k > 0 && k % 16 == 0), 1'b1, 1'b1));
        end

        $display("[TB] phase-continuous retune");
        doReset("rt_reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000, 10'h0, mk("rt_load", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h0, mk("rt_start", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b1, (k >= 5 && k <= 14), (k == 5) ? 16'h2000 : 16'h7777, 10'h0,
                          mk("retune", (k < 16) ? k * 'h40 : (k - 16) * 'h80, 1'b1, (k >= 4),
                             (k >= 16 && (k - 16) % 8 == 0), !(k >= 5 && k <= 14), 1'b1));
        end

        $display("[TB] zero-FTW retune");
        doReset("zf_reset");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h0, mk("zf_start", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b1, (k == 2 || k == 3), (k == 2) ? 16'h0040 : 16'h5555, 10'h0,
                          mk("zero_ftw", (k <= 4) ? 0 : k - 4, 1'b1, (k >= 4), 1'b0, (k != 2), 1'b1));
        end

        $display("[TB] mid-operation reset");
        doReset("mr_reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000, 10'h0, mk("mr_load", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h0, mk("mr_start", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k <= 2; k++) begin
            applyStimulus(1'b0, 1'b1, (k == 2), 16'h2000, 10'h0,
                          mk("mr_run", k * 'h40, 1'b1, 1'b0, 1'b0, (k != 2), 1'b1));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 10'h0, mk("mr_assert", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 10'h0, mk("mr_idle", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h0, mk("mr_restart", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 10'h0,
                          mk("mr_ftw_zero", 0, 1'b1, (k >= 4), 1'b0, 1'b1, 1'b1));
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
